ahb_master_pipe: RTL and testbench
==================================

# ahb_master_pipe

Parametrised, pipelined AHB-Lite master for the AHB bus subsystem. It accepts commands over a valid/ready interface and buffers them in a command FIFO. It overlaps the address phase of one transfer with the data phase of the previous one, handles slave wait states and two-cycle ERROR responses, steers byte lanes for DATA_WIDTH of 32 or 64, and returns one response per command through a backpressured response FIFO.

## Interface
- ADDR_WIDTH, 32, address width of haddr_o and cmd_addr_i.
- DATA_WIDTH, 32, bus data width; only 32 or 64 are legal.
- CMD_DEPTH, 4, command FIFO depth; power of two, at least 2.
- HPROT_VAL, 4'b0011, constant driven on hprot_o.
- hclk  in  1  AHB clock; all logic is on the rising edge.
- hresetn  in  1  reset, asynchronous, active-low.
- cmd_vld_i  in  1  command valid.
- cmd_rdy_o  out  1  command FIFO not full.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_size_i  in  3  HSIZE encoding of the transfer.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_wdata_i  in  DATA_WIDTH  write data, LSB-aligned.
- rsp_vld_o  out  1  response valid.
- rsp_rdy_i  in  1  response accepted.
- rsp_write_o  out  1  the response belongs to a write.
- rsp_err_o  out  1  slave ERROR or illegal command.
- rsp_rdata_o  out  DATA_WIDTH  read data, LSB-aligned and zero-extended; 0 for writes.
- haddr_o  out  ADDR_WIDTH  AHB address.
- htrans_o  out  2  IDLE (00) or NONSEQ (10).
- hwrite_o  out  1  AHB write.
- hsize_o  out  3  AHB size.
- hburst_o  out  3  constant 3'b000 (SINGLE).
- hprot_o  out  4  constant HPROT_VAL.
- hmastlock_o  out  1  constant 0.
- hwdata_o  out  DATA_WIDTH  lane-steered write data during the data phase.
- hready_i  in  1  HREADY.
- hresp_i  in  1  HRESP, where 1 = ERROR.
- hrdata_i  in  DATA_WIDTH  read data.

## Operation
- **Command FIFO:** a command is pushed on cmd_vld_i & cmd_rdy_o. The FIFO head drives haddr_o, hwrite_o and hsize_o combinationally.
- **Legality check:** with LB = log2(DATA_WIDTH/8), a command is illegal if cmd_size_i > LB or if the address is not aligned to the size.
  - An illegal command at the head is never put on the bus.
  - When the head is illegal and no transfer is in its data phase, the command is popped and a response with rsp_err_o = 1 and rdata = 0 is pushed into the response FIFO.
- **Response FIFO:** 2 entries, registered outputs. Credits = (data phase busy) + (response FIFO count) − (pop this cycle).
- **Issue rule:** htrans_o = NONSEQ when all of the following hold; otherwise htrans_o = IDLE.
  - The head is legal.
  - Credits < 2.
  - The cycle is not the first cycle of an ERROR response.
- **Address phase completion:** the address phase completes on a cycle with NONSEQ & hready_i. At that point the command is popped and moves to the data-phase register, which holds write flag, address low bits, size and steered wdata.
- **Write steering:** hwdata_o = wdata << (8 × addr[LB−1:0]). hwdata_o is driven throughout the data phase and is 0 otherwise.
- **Read steering:** rdata = (hrdata_i >> (8 × addr[LB−1:0])), then masked to 2^size bytes.
- **Data phase completion:** the data phase completes on hready_i = 1. It pushes a response carrying rsp_err_o = hresp_i.
- **ERROR response:** the first cycle (hresp_i = 1, hready_i = 0) forces htrans_o = IDLE. The command in its address phase is not popped and is re-issued after the error completes. Later commands are still executed; the master does not abort them.
- **Response ordering:** responses are delivered strictly in command order.

## Timing
- **Reset values:**
  - rsp_vld_o, rsp_err_o, rsp_write_o, rsp_rdata_o = 0.
  - htrans_o = IDLE, haddr_o = 0, hwrite_o = 0, hsize_o = 0, hwdata_o = 0.
  - cmd_rdy_o = 1 one cycle after reset deassertion.
- **Zero-wait latency:** command pushed at edge N → NONSEQ in cycle N+1 → data phase in cycle N+2 → rsp_vld_o in cycle N+3.
- **Throughput:** back-to-back commands issue one NONSEQ per cycle while rsp_rdy_i = 1.
- **Wait states:** hready_i = 0 holds every AHB output stable, including haddr_o and htrans_o of a pending NONSEQ.
- **Full FIFO:** when the command FIFO is full, cmd_rdy_o = 0. A push and a pop in the same cycle are allowed while the FIFO is full.
- **Response backpressure:** with rsp_rdy_i = 0 and the response FIFO full, htrans_o stays IDLE. No data-phase result is ever dropped.
- **Empty FIFO:** htrans_o = IDLE.
- **Pointer wrap:** FIFO pointers wrap modulo CMD_DEPTH with an extra wrap bit for full/empty detection.
- **Reset mid-operation:** all FIFOs are cleared and the outputs return to their reset values immediately. Any in-flight transfer is lost.

## Test plan
- **Zero-wait read:** DATA_WIDTH = 32; read addr 0x12, size 0 with hrdata 0xAABBCCDD → rsp_rdata_o = 0x000000BB, err = 0, rsp_vld_o 3 cycles after the push.
- **Back-to-back writes:** writes to 0x0 (0x11111111), 0x4 (0x22222222) and 0x6 (size 1, 0x3344). Required response:
  - NONSEQ on 3 consecutive cycles.
  - hwdata_o = 0x11111111, then 0x22222222, then 0x33440000.
  - Three responses with err = 0.
- **Wait states:** a read with hready_i low for 3 data-phase cycles while a second command is pending → haddr_o and htrans_o of the second command stay stable, and the responses arrive in order.
- **Slave ERROR:** an ERROR response on a write to 0x8 with a read to 0xC pending. Required response:
  - htrans_o = IDLE in the first ERROR cycle.
  - The read to 0xC is re-issued afterwards.
  - Responses: err = 1, then err = 0.
- **Illegal commands:** size 2 at 0x2, and size 3 with DATA_WIDTH = 32 → no NONSEQ; responses with err = 1 and rdata = 0.
- **Backpressure and reset:** hold rsp_rdy_i = 0 while pushing CMD_DEPTH + 2 commands. Required response:
  - cmd_rdy_o drops.
  - At most 2 transfers complete, then htrans_o stays IDLE.
  - Releasing rsp_rdy_i drains all commands in order.
  - Asserting hresetn low mid-stream → all outputs return to their reset values.

Source files
------------

// File: rtl/ahb_master_pipe.sv
// Pipelined AHB-Lite master. Commands flow through a command FIFO, an
// address phase driven straight from the FIFO head, a data-phase register and
// a two-entry response FIFO. Only SINGLE transfers are generated.
module ahb_master_pipe #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_vld_i,
  output logic                  cmd_rdy_o,
  input  logic                  cmd_write_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_vld_o,
  input  logic                  rsp_rdy_i,
  output logic                  rsp_write_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic                  hmastlock_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic                  hready_i,
  input  logic                  hresp_i,
  input  logic [DATA_WIDTH-1:0] hrdata_i
);

  localparam int unsigned LB     = $clog2(DATA_WIDTH / 8);
  localparam int          NBYTES = DATA_WIDTH / 8;
  localparam int unsigned PW     = $clog2(CMD_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  illegal;
    logic                  write;
    logic [2:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                  vld;
    logic                  write;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  // A command is illegal if wider than the bus or not naturally aligned.
  function automatic logic is_illegal(input logic [2:0] size, input logic [ADDR_WIDTH-1:0] addr);
    logic [LB-1:0] mask;
    if (size > 3'(LB)) return 1'b1;
    mask = LB'((32'd1 << size) - 32'd1);
    return (addr[LB-1:0] & mask) != '0;
  endfunction

  // ---------------- command FIFO ----------------
  cmd_t        cmd_mem_q [CMD_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        rst_done_q;
  cmd_t        cmd_new, head;
  logic        cmd_empty, cmd_full, cmd_push, cmd_pop;

  assign cmd_empty = (wr_ptr_q == rd_ptr_q);
  assign cmd_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head      = cmd_mem_q[rd_ptr_q[PW-1:0]];
  assign cmd_rdy_o = rst_done_q & (~cmd_full | cmd_pop);
  assign cmd_push  = cmd_vld_i & cmd_rdy_o;
  assign cmd_new   = '{illegal: is_illegal(cmd_size_i, cmd_addr_i), write: cmd_write_i,
                       size: cmd_size_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
  assign wr_ptr_d  = cmd_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d  = cmd_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // FIFO pointers and the ready-after-reset flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rst_done_q <= 1'b1;
    end
  end

  // Command storage write port.
  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge hclk) begin
    if (cmd_push) cmd_mem_q[wr_ptr_q[PW-1:0]] <= cmd_new;
  end

  // ---------------- issue control ----------------
  logic                  dp_busy_q, dp_busy_d, dp_write_q, dp_write_d;
  logic [LB-1:0]         dp_lo_q, dp_lo_d;
  logic [2:0]            dp_size_q, dp_size_d;
  logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;
  rsp_t                  rsp_out_q, rsp_out_d, rsp_skid_q, rsp_skid_d, rsp_new;
  logic [1:0]            rsp_cnt;
  logic [2:0]            credits;
  logic                  rsp_pop, rsp_push, has_room, err_first, dp_done;
  logic                  issue, addr_done, illegal_pop;

  assign rsp_pop     = rsp_out_q.vld & rsp_rdy_i;
  assign rsp_cnt     = {1'b0, rsp_out_q.vld} + {1'b0, rsp_skid_q.vld};
  assign credits     = {2'b00, dp_busy_q} + {1'b0, rsp_cnt} - {2'b00, rsp_pop};
  assign has_room    = credits < 3'd2;
  assign err_first   = dp_busy_q & hresp_i & ~hready_i;
  assign dp_done     = dp_busy_q & hready_i;
  assign issue       = ~cmd_empty & ~head.illegal & has_room & ~err_first;
  assign addr_done   = issue & hready_i;
  assign illegal_pop = ~cmd_empty & head.illegal & ~dp_busy_q & has_room;
  assign cmd_pop     = addr_done | illegal_pop;
  assign rsp_push    = dp_done | illegal_pop;

  // AHB address/control outputs come straight from the FIFO head.
  assign htrans_o    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o     = cmd_empty ? '0 : head.addr;
  assign hwrite_o    = ~cmd_empty & head.write;
  assign hsize_o     = cmd_empty ? 3'b000 : head.size;
  assign hburst_o    = 3'b000;
  assign hprot_o     = HPROT_VAL;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = (dp_busy_q & dp_write_q) ? dp_wdata_q : '0;

  // Data-phase register: loaded when an address phase completes.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dp_busy_d  = dp_busy_q;
    dp_write_d = dp_write_q;
    dp_lo_d    = dp_lo_q;
    dp_size_d  = dp_size_q;
    dp_wdata_d = dp_wdata_q;
    if (hready_i) begin
      dp_busy_d = addr_done;
      if (addr_done) begin
        dp_write_d = head.write;
        dp_lo_d    = head.addr[LB-1:0];
        dp_size_d  = head.size;
        dp_wdata_d = head.wdata << {head.addr[LB-1:0], 3'b000};
      end
    end
  end

  // Read steering and response construction, then the two-entry response FIFO.
  always_comb begin
    logic [DATA_WIDTH-1:0] rd_shift, rd_masked;
    rd_shift  = hrdata_i >> {dp_lo_q, 3'b000};
    rd_masked = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < (1 << dp_size_q)) rd_masked[8*b +: 8] = rd_shift[8*b +: 8];
    end
    rsp_new.vld   = 1'b1;
    rsp_new.write = dp_busy_q ? dp_write_q : head.write;
    rsp_new.err   = dp_busy_q ? hresp_i : 1'b1;
    rsp_new.rdata = (dp_busy_q & ~dp_write_q) ? rd_masked : '0;

    rsp_out_d  = rsp_out_q;
    rsp_skid_d = rsp_skid_q;
    if (rsp_pop) begin
      if (rsp_skid_q.vld) begin
        rsp_out_d  = rsp_skid_q;
        rsp_skid_d = rsp_push ? rsp_new : '0;
      end else begin
        rsp_out_d  = rsp_push ? rsp_new : '0;
      end
    end else if (rsp_push) begin
      if (rsp_out_q.vld) rsp_skid_d = rsp_new;
      else               rsp_out_d  = rsp_new;
    end
  end

  assign rsp_vld_o   = rsp_out_q.vld;
  assign rsp_write_o = rsp_out_q.write;
  assign rsp_err_o   = rsp_out_q.err;
  assign rsp_rdata_o = rsp_out_q.rdata;

  // Data-phase and response FIFO registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_busy_q  <= 1'b0;
      dp_write_q <= 1'b0;
      dp_lo_q    <= '0;
      dp_size_q  <= 3'b000;
      dp_wdata_q <= '0;
      rsp_out_q  <= '0;
      rsp_skid_q <= '0;
    end else begin
      dp_busy_q  <= dp_busy_d;
      dp_write_q <= dp_write_d;
      dp_lo_q    <= dp_lo_d;
      dp_size_q  <= dp_size_d;
      dp_wdata_q <= dp_wdata_d;
      rsp_out_q  <= rsp_out_d;
      rsp_skid_q <= rsp_skid_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_pipe.sv
// Directed bench for ahb_master_pipe (32-bit data, 4-deep command FIFO).
module tb_ahb_master_pipe;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_vld_i, cmd_rdy_o, cmd_write_i;
  logic [2:0]  cmd_size_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_vld_o, rsp_rdy_i, rsp_write_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        hready_i, hresp_i;
  logic [31:0] hrdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] bp_addr [6];
  logic [2:0]  bp_size [6];
  logic [31:0] bp_exp  [6];

  ahb_master_pipe #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .HPROT_VAL(4'b0011)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o), .cmd_write_i(cmd_write_i),
    .cmd_size_i(cmd_size_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_write_o(rsp_write_o),
    .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
    .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o),
    .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_cmd(input logic wr, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    cmd_vld_i   = 1'b1;
    cmd_write_i = wr;
    cmd_size_i  = sz;
    cmd_addr_i  = ad;
    cmd_wdata_i = wd;
  endtask

  initial begin
    int idx;
    bp_addr = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h46};
    bp_size = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    bp_exp  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h2211, 32'h4433};

    hresetn = 1'b0; cmd_vld_i = 1'b0; cmd_write_i = 1'b0; cmd_size_i = 3'd0;
    cmd_addr_i = '0; cmd_wdata_i = '0; rsp_rdy_i = 1'b1;
    hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;

    // ---- reset values ----
    #3;
    check("rst_rsp_vld", rsp_vld_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_write", rsp_write_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_htrans", htrans_o, 0);
    check("rst_haddr", haddr_o, 0);
    check("rst_hwrite", hwrite_o, 0);
    check("rst_hsize", hsize_o, 0);
    check("rst_hwdata", hwdata_o, 0);
    check("hburst", hburst_o, 0);
    check("hprot", hprot_o, 4'b0011);
    check("hmastlock", hmastlock_o, 0);
    step(); step();
    hresetn = 1'b1;
    step();
    check("rdy_after_reset", cmd_rdy_o, 1);

    // ---- zero-wait read: 0x12 size 0 ----
    set_cmd(1'b0, 3'd0, 32'h12, 32'h0);
    step();
    cmd_vld_i = 1'b0; #1;
    check("zw_htrans", htrans_o, 2'b10);
    check("zw_haddr", haddr_o, 32'h12);
    check("zw_hwrite", hwrite_o, 0);
    step();
    hrdata_i = 32'hAABBCCDD; #1;
    check("zw_dp_idle", htrans_o, 2'b00);
    check("zw_dp_novld", rsp_vld_o, 0);
    step();
    check("zw_rsp_vld", rsp_vld_o, 1);
    check("zw_rsp_rdata", rsp_rdata_o, 32'h000000BB);
    check("zw_rsp_err", rsp_err_o, 0);
    check("zw_rsp_write", rsp_write_o, 0);
    step();
    check("zw_rsp_gone", rsp_vld_o, 0);

    // ---- back-to-back writes ----
    set_cmd(1'b1, 3'd2, 32'h0, 32'h11111111);
    step();
    set_cmd(1'b1, 3'd2, 32'h4, 32'h22222222); #1;
    check("b2b_ns0", htrans_o, 2'b10);
    check("b2b_addr0", haddr_o, 32'h0);
    check("b2b_hwrite0", hwrite_o, 1);
    step();
    set_cmd(1'b1, 3'd1, 32'h6, 32'h3344); #1;
    check("b2b_ns1", htrans_o, 2'b10);
    check("b2b_addr1", haddr_o, 32'h4);
    check("b2b_wdata0", hwdata_o, 32'h11111111);
    step();
    cmd_vld_i = 1'b0; #1;
    check("b2b_ns2", htrans_o, 2'b10);
    check("b2b_addr2", haddr_o, 32'h6);
    check("b2b_size2", hsize_o, 3'd1);
    check("b2b_wdata1", hwdata_o, 32'h22222222);
    check("b2b_rsp0_vld", rsp_vld_o, 1);
    check("b2b_rsp0_write", rsp_write_o, 1);
    check("b2b_rsp0_err", rsp_err_o, 0);
    step();
    check("b2b_idle", htrans_o, 2'b00);
    check("b2b_wdata2", hwdata_o, 32'h33440000);
    check("b2b_rsp1_vld", rsp_vld_o, 1);
    check("b2b_rsp1_err", rsp_err_o, 0);
    step();
    check("b2b_rsp2_vld", rsp_vld_o, 1);
    check("b2b_rsp2_err", rsp_err_o, 0);
    check("b2b_wdata_off", hwdata_o, 0);
    step();
    check("b2b_drained", rsp_vld_o, 0);

    // ---- wait states: read 0x20 stalled 3 cycles, read 0x24 pending ----
    set_cmd(1'b0, 3'd2, 32'h20, 32'h0);
    step();
    set_cmd(1'b0, 3'd2, 32'h24, 32'h0);
    step();
    cmd_vld_i = 1'b0;
    for (int w = 0; w < 3; w++) begin
      hready_i = 1'b0; #1;
      check($sformatf("ws_htrans_%0d", w), htrans_o, 2'b10);
      check($sformatf("ws_haddr_%0d", w), haddr_o, 32'h24);
      check($sformatf("ws_novld_%0d", w), rsp_vld_o, 0);
      step();
    end
    hready_i = 1'b1; hrdata_i = 32'h11223344; #1;
    check("ws_release_htrans", htrans_o, 2'b10);
    check("ws_release_haddr", haddr_o, 32'h24);
    step();
    hrdata_i = 32'h55667788; #1;
    check("ws_rsp0_vld", rsp_vld_o, 1);
    check("ws_rsp0_rdata", rsp_rdata_o, 32'h11223344);
    check("ws_idle", htrans_o, 2'b00);
    step();
    check("ws_rsp1_vld", rsp_vld_o, 1);
    check("ws_rsp1_rdata", rsp_rdata_o, 32'h55667788);
    step();

    // ---- slave ERROR on write 0x8 with read 0xC pending ----
    set_cmd(1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
    step();
    set_cmd(1'b0, 3'd2, 32'hC, 32'h0);
    step();
    cmd_vld_i = 1'b0; hready_i = 1'b0; hresp_i = 1'b1; #1;
    check("err1_htrans_idle", htrans_o, 2'b00);
    check("err1_haddr", haddr_o, 32'hC);
    check("err1_hwdata", hwdata_o, 32'hDEADBEEF);
    step();
    hready_i = 1'b1; hresp_i = 1'b1; #1;
    check("err2_reissue", htrans_o, 2'b10);
    check("err2_haddr", haddr_o, 32'hC);
    step();
    hresp_i = 1'b0; hrdata_i = 32'hCAFEF00D; #1;
    check("err_rsp0_vld", rsp_vld_o, 1);
    check("err_rsp0_err", rsp_err_o, 1);
    check("err_rsp0_write", rsp_write_o, 1);
    check("err_rsp0_rdata", rsp_rdata_o, 0);
    check("err_idle", htrans_o, 2'b00);
    step();
    check("err_rsp1_vld", rsp_vld_o, 1);
    check("err_rsp1_err", rsp_err_o, 0);
    check("err_rsp1_rdata", rsp_rdata_o, 32'hCAFEF00D);
    step();

    // ---- illegal commands ----
    set_cmd(1'b0, 3'd2, 32'h2, 32'h0);
    step();
    set_cmd(1'b1, 3'd3, 32'h0, 32'h12345678); #1;
    check("ill_idle0", htrans_o, 2'b00);
    step();
    cmd_vld_i = 1'b0; #1;
    check("ill_idle1", htrans_o, 2'b00);
    check("ill_rsp0_vld", rsp_vld_o, 1);
    check("ill_rsp0_err", rsp_err_o, 1);
    check("ill_rsp0_write", rsp_write_o, 0);
    check("ill_rsp0_rdata", rsp_rdata_o, 0);
    step();
    check("ill_idle2", htrans_o, 2'b00);
    check("ill_rsp1_vld", rsp_vld_o, 1);
    check("ill_rsp1_err", rsp_err_o, 1);
    check("ill_rsp1_write", rsp_write_o, 1);
    check("ill_rsp1_rdata", rsp_rdata_o, 0);
    step();
    check("ill_drained", rsp_vld_o, 0);

    // ---- response backpressure with CMD_DEPTH+2 commands ----
    rsp_rdy_i = 1'b0; hrdata_i = 32'h44332211;
    for (int k = 0; k < 6; k++) begin
      set_cmd(1'b0, bp_size[k], bp_addr[k], 32'h0); #1;
      check($sformatf("bp_rdy_%0d", k), cmd_rdy_o, 1);
      step();
    end
    cmd_vld_i = 1'b0; #1;
    check("bp_full_rdy", cmd_rdy_o, 0);
    check("bp_hold_vld", rsp_vld_o, 1);
    check("bp_hold_rdata", rsp_rdata_o, bp_exp[0]);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp_stall_idle_%0d", s), htrans_o, 2'b00);
      check($sformatf("bp_stall_rdy_%0d", s), cmd_rdy_o, 0);
      step();
    end
    rsp_rdy_i = 1'b1; #1;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      if (rsp_vld_o) begin
        check($sformatf("bp_rsp%0d_rdata", idx), rsp_rdata_o, bp_exp[idx]);
        check($sformatf("bp_rsp%0d_err", idx), rsp_err_o, 0);
        idx++;
      end
      step();
    end
    check("bp_drain_count", idx, 6);

    // ---- reset in mid-stream ----
    rsp_rdy_i = 1'b0;
    set_cmd(1'b1, 3'd2, 32'h80, 32'h99999999);
    step();
    set_cmd(1'b1, 3'd2, 32'h84, 32'h77777777);
    step();
    set_cmd(1'b1, 3'd2, 32'h88, 32'h55555555);
    step();
    cmd_vld_i = 1'b0; #1;
    check("mid_rsp_vld", rsp_vld_o, 1);
    check("mid_haddr", haddr_o, 32'h88);
    check("mid_hwdata", hwdata_o, 32'h77777777);
    hresetn = 1'b0; #1;
    check("mrst_rsp_vld", rsp_vld_o, 0);
    check("mrst_rsp_write", rsp_write_o, 0);
    check("mrst_rsp_err", rsp_err_o, 0);
    check("mrst_rsp_rdata", rsp_rdata_o, 0);
    check("mrst_htrans", htrans_o, 0);
    check("mrst_haddr", haddr_o, 0);
    check("mrst_hwrite", hwrite_o, 0);
    check("mrst_hsize", hsize_o, 0);
    check("mrst_hwdata", hwdata_o, 0);
    rsp_rdy_i = 1'b1;
    step(); step();
    hresetn = 1'b1;
    step();
    check("mrst_rdy", cmd_rdy_o, 1);
    check("mrst_cleared_htrans", htrans_o, 0);
    check("mrst_cleared_vld", rsp_vld_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
